instruction_deserializer: RTL

Bit-serial instruction receiver between the MBED controller and the servo sequencing FSM. Accepts one `command` bit per four-phase `confirm`/`data_ready` handshake, assembles a 10-bit servo instruction MSB first (opcode bits [9:8], then position [7:0]), and presents it on `servo_instr` with a level `instruction_ready` held until the sequencer acknowledges it. Includes input synchronisation, an inter-bit timeout that discards partial frames, and optional parity checking.

---
 rtl/instruction_deserializer_if.sv | 23 ++
 rtl/instruction_deserializer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/instruction_deserializer_if.sv
// Handshake bundle between the MBED-side serial link and the instruction deserializer.
// The master drives the serial bit, strobe and acknowledge. The slave returns the instruction and status.
interface instruction_deserializer_if #(
    parameter int WIDTH = 10
);
    logic             command;
    logic             confirm;
    logic             instr_ack;
    logic [WIDTH-1:0] servo_instr;
    logic             instruction_ready;
    logic             data_ready;
    logic             frame_err;

    modport master (
        output command, confirm, instr_ack,
        input  servo_instr, instruction_ready, data_ready, frame_err
    );

    modport slave (
        input  command, confirm, instr_ack,
        output servo_instr, instruction_ready, data_ready, frame_err
    );
endinterface

// File: rtl/instruction_deserializer.sv
// Bit-serial servo instruction receiver: one bit per confirm/data_ready four-phase handshake.
// When INSTR_PARITY_EN is defined, an even-parity bit is appended to the frame and checked.
module instruction_deserializer #(
    parameter int WIDTH          = 10,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    instruction_deserializer_if.slave  bus
);

`ifdef INSTR_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // state | meaning
    // IDLE  | data_ready low, waiting for the synchronised confirm to rise
    // ACK   | bit captured, data_ready high, waiting for confirm to fall
    // FULL  | instruction presented, confirm ignored until instr_ack
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_cmd_sync;
    logic [SYNC_STAGES-1:0] r_cfm_sync;
    logic [FRAME_LEN-1:0]   r_sr;
    logic [CNT_W-1:0]       r_cnt;
    logic [TMO_W-1:0]       r_tmo;
    logic [WIDTH-1:0]       r_servo_instr;
    logic                   r_instruction_ready;
    logic                   r_data_ready;
    logic                   r_frame_err;

    logic                   w_cmd_s;
    logic                   w_cfm_s;
    logic                   w_tmo_run;
    logic                   w_tmo_fire;
    logic                   w_valid;
    logic [WIDTH-1:0]       w_payload;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cmd_sync <= '0;
            r_cfm_sync <= '0;
        end else begin
            r_cmd_sync <= {r_cmd_sync[SYNC_STAGES-2:0], bus.command};
            r_cfm_sync <= {r_cfm_sync[SYNC_STAGES-2:0], bus.confirm};
        end
    end

    assign w_cmd_s = r_cmd_sync[SYNC_STAGES-1];
    assign w_cfm_s = r_cfm_sync[SYNC_STAGES-1];

    // A partial frame is timed while waiting for either handshake edge.
    // A frame with no bits yet is never timed.
    assign w_tmo_run  = (r_state == ACK) || ((r_state == IDLE) && (r_cnt != '0));
    assign w_tmo_fire = w_tmo_run && (r_tmo == TMO_LAST);

`ifdef INSTR_PARITY_EN
    // The parity bit arrives last, so it sits in the LSB and the instruction sits above it.
    assign w_valid   = ~(^r_sr);
    assign w_payload = r_sr[FRAME_LEN-1:1];
`else
    assign w_valid   = 1'b1;
    assign w_payload = r_sr;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state             <= IDLE;
            r_sr                <= '0;
            r_cnt               <= '0;
            r_tmo               <= '0;
            r_servo_instr       <= '0;
            r_instruction_ready <= 1'b0;
            r_data_ready        <= 1'b0;
            r_frame_err         <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_tmo_fire) begin
                // If a handshake edge arrives on the same clock, the timeout takes priority.
                r_frame_err  <= 1'b1;
                r_cnt        <= '0;
                r_sr         <= '0;
                r_tmo        <= '0;
                r_data_ready <= 1'b0;
                r_state      <= IDLE;
            end else begin
                if (w_tmo_run) begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
                case (r_state)
                    IDLE: begin
                        if (w_cfm_s) begin
                            r_sr         <= {r_sr[FRAME_LEN-2:0], w_cmd_s};
                            r_cnt        <= r_cnt + CNT_W'(1);
                            r_tmo        <= '0;
                            r_data_ready <= 1'b1;
                            r_state      <= ACK;
                        end
                    end
                    ACK: begin
                        if (!w_cfm_s) begin
                            r_data_ready <= 1'b0;
                            r_tmo        <= '0;
                            r_state      <= IDLE;
                            if (r_cnt == CNT_FULL) begin
                                r_cnt <= '0;
                                if (w_valid) begin
                                    r_servo_instr       <= w_payload;
                                    r_instruction_ready <= 1'b1;
                                    r_state             <= FULL;
                                end else begin
                                    r_frame_err <= 1'b1;
                                    r_sr        <= '0;
                                end
                            end
                        end
                    end
                    FULL: begin
                        if (bus.instr_ack) begin
                            r_instruction_ready <= 1'b0;
                            r_state             <= IDLE;
                        end
                    end
                    default: begin
                        r_state      <= IDLE;
                        r_data_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.servo_instr       = r_servo_instr;
    assign bus.instruction_ready = r_instruction_ready;
    assign bus.data_ready        = r_data_ready;
    assign bus.frame_err         = r_frame_err;

endmodule
